// File: rtl/axi_lite_arbiter_2to1.sv
// Round-robin 2:1 AXI-Lite arbiter: one transaction in flight, granted master forwarded.
// Optional response watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_WDTH      = 4,
  parameter int DATA_WDTH      = 32,
  parameter int RESP_WDTH      = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             m_ar_valid,
  output logic [1:0]             m_ar_ready,
  input  logic [2*ADDR_WDTH-1:0] m_ar_address,
  output logic [1:0]             m_r_valid,
  input  logic [1:0]             m_r_ready,
  output logic [DATA_WDTH-1:0]   m_r_data,
  output logic [RESP_WDTH-1:0]   m_r_resp,
  input  logic [1:0]             m_aw_valid,
  output logic [1:0]             m_aw_ready,
  input  logic [2*ADDR_WDTH-1:0] m_aw_address,
  input  logic [1:0]             m_w_valid,
  output logic [1:0]             m_w_ready,
  input  logic [2*DATA_WDTH-1:0] m_w_data,
  output logic [1:0]             m_b_valid,
  input  logic [1:0]             m_b_ready,
  output logic [RESP_WDTH-1:0]   m_b_resp,
  output logic                   s_ar_valid,
  input  logic                   s_ar_ready,
  output logic [ADDR_WDTH-1:0]   s_ar_address,
  input  logic                   s_r_valid,
  output logic                   s_r_ready,
  input  logic [DATA_WDTH-1:0]   s_r_data,
  input  logic [RESP_WDTH-1:0]   s_r_resp,
  output logic                   s_aw_valid,
  input  logic                   s_aw_ready,
  output logic [ADDR_WDTH-1:0]   s_aw_address,
  output logic                   s_w_valid,
  input  logic                   s_w_ready,
  output logic [DATA_WDTH-1:0]   s_w_data,
  input  logic                   s_b_valid,
  output logic                   s_b_ready,
  input  logic [RESP_WDTH-1:0]   s_b_resp,
  output logic                   grant_valid,
  output logic                   grant_id,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AR_PHASE = 3'd1,
    R_PHASE  = 3'd2,
    AW_PHASE = 3'd3,
    W_PHASE  = 3'd4,
    B_PHASE  = 3'd5
`ifdef ARB_TIMEOUT_EN
    ,
    TIMEOUT_RESP = 3'd6
`endif
  } state_e;

  state_e state_q, state_d;
  logic   grant_id_q, grant_id_d;
  logic   last_grant_q, last_grant_d;
  logic   g;
  logic   pick;
  logic [1:0] req;

  logic [ADDR_WDTH-1:0] ar_addr_g;
  logic [ADDR_WDTH-1:0] aw_addr_g;
  logic [DATA_WDTH-1:0] w_data_g;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_rd_q, to_rd_d;
  logic             to_err_q, to_err_d;
`endif

  assign g   = grant_id_q;
  assign req = m_ar_valid | m_aw_valid;

  assign ar_addr_g = g ? m_ar_address[2*ADDR_WDTH-1:ADDR_WDTH]
                       : m_ar_address[ADDR_WDTH-1:0];
  assign aw_addr_g = g ? m_aw_address[2*ADDR_WDTH-1:ADDR_WDTH]
                       : m_aw_address[ADDR_WDTH-1:0];
  assign w_data_g  = g ? m_w_data[2*DATA_WDTH-1:DATA_WDTH]
                       : m_w_data[DATA_WDTH-1:0];

  assign grant_valid = (state_q != IDLE);
  assign grant_id    = grant_id_q;

  // Round-robin pick: a tie goes to the master not served last.
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (req == 2'b11): pick = ~last_grant_q;
      (req == 2'b10): pick = 1'b1;
      default:        pick = 1'b0;
    endcase
  end

  // Next state and channel forwarding for the granted master.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    m_ar_ready   = '0;
    m_r_valid    = '0;
    m_r_data     = '0;
    m_r_resp     = '0;
    m_aw_ready   = '0;
    m_w_ready    = '0;
    m_b_valid    = '0;
    m_b_resp     = '0;
    s_ar_valid   = 1'b0;
    s_ar_address = '0;
    s_r_ready    = 1'b0;
    s_aw_valid   = 1'b0;
    s_aw_address = '0;
    s_w_valid    = 1'b0;
    s_w_data     = '0;
    s_b_ready    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = '0;
    to_rd_d  = to_rd_q;
    to_err_d = to_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_id_d = pick;
          state_d    = m_ar_valid[pick] ? AR_PHASE : AW_PHASE;
        end
      end
      AR_PHASE: begin
        s_ar_valid    = m_ar_valid[g];
        s_ar_address  = ar_addr_g;
        m_ar_ready[g] = s_ar_ready;
        if (m_ar_valid[g] && s_ar_ready) state_d = R_PHASE;
      end
      R_PHASE: begin
        m_r_valid[g] = s_r_valid;
        s_r_ready    = m_r_ready[g];
        m_r_data     = s_r_data;
        m_r_resp     = s_r_resp;
        if (s_r_valid && m_r_ready[g]) begin
          state_d      = IDLE;
          last_grant_d = g;
        end
`ifdef ARB_TIMEOUT_EN
        if (!s_r_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) begin
            state_d = TIMEOUT_RESP;
            to_rd_d = 1'b1;
          end
        end
`endif
      end
      AW_PHASE: begin
        s_aw_valid    = m_aw_valid[g];
        s_aw_address  = aw_addr_g;
        m_aw_ready[g] = s_aw_ready;
        if (m_aw_valid[g] && s_aw_ready) state_d = W_PHASE;
      end
      W_PHASE: begin
        s_w_valid    = m_w_valid[g];
        s_w_data     = w_data_g;
        m_w_ready[g] = s_w_ready;
        if (m_w_valid[g] && s_w_ready) state_d = B_PHASE;
      end
      B_PHASE: begin
        m_b_valid[g] = s_b_valid;
        s_b_ready    = m_b_ready[g];
        m_b_resp     = s_b_resp;
        if (s_b_valid && m_b_ready[g]) begin
          state_d      = IDLE;
          last_grant_d = g;
        end
`ifdef ARB_TIMEOUT_EN
        if (!s_b_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) begin
            state_d = TIMEOUT_RESP;
            to_rd_d = 1'b0;
          end
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      TIMEOUT_RESP: begin
        if (to_rd_q) begin
          m_r_valid[g] = 1'b1;
          if (m_r_ready[g]) begin
            state_d      = IDLE;
            last_grant_d = g;
            to_err_d     = 1'b1;
          end
        end else begin
          m_b_valid[g] = 1'b1;
          if (m_b_ready[g]) begin
            state_d      = IDLE;
            last_grant_d = g;
            to_err_d     = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      to_rd_q  <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_rd_q  <= to_rd_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1 with a memory-like slave model.
// Expected responses and grants are queued at issue time and popped by a monitor.
module tb_axi_lite_arbiter_2to1;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int RW  = 1;
  localparam int TMO = 300;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk, rst;
  logic [1:0] m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [1:0] m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [1:0] m_b_valid, m_b_ready;
  logic [2*AW-1:0] m_ar_address, m_aw_address;
  logic [2*DW-1:0] m_w_data;
  logic [DW-1:0] m_r_data;
  logic [RW-1:0] m_r_resp, m_b_resp;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
  logic s_b_valid, s_b_ready;
  logic [AW-1:0] s_ar_address, s_aw_address;
  logic [DW-1:0] s_r_data, s_w_data;
  logic [RW-1:0] s_r_resp, s_b_resp;
  logic grant_valid, grant_id, timeout_err;

  int total = 0;
  int bad = 0;

  logic [32:0] exp_r0[$];
  logic [32:0] exp_r1[$];
  logic        exp_g[$];
  int          pend_b[2];
  logic [DW-1:0] ref_mem[16];

  axi_lite_arbiter_2to1 #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_address(m_ar_address),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_aw_address(m_aw_address),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_ar_address(s_ar_address),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_aw_address(s_aw_address),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-outstanding memory slave model.
  logic [DW-1:0] smem[16];
  logic          rv_q, awg_q, bv_q, stall_r;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] waddr_q;

  assign s_ar_ready = !rv_q && !awg_q && !bv_q;
  assign s_r_valid  = rv_q && !stall_r;
  assign s_r_data   = rdata_q;
  assign s_r_resp   = 1'b1;
  assign s_aw_ready = !rv_q && !awg_q && !bv_q;
  assign s_w_ready  = awg_q && !bv_q;
  assign s_b_valid  = bv_q;
  assign s_b_resp   = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      rv_q  <= 1'b0;
      awg_q <= 1'b0;
      bv_q  <= 1'b0;
    end else begin
      if (s_ar_valid && s_ar_ready) begin
        rv_q    <= 1'b1;
        rdata_q <= smem[s_ar_address];
      end
      if (s_r_valid && s_r_ready) rv_q <= 1'b0;
      if (s_aw_valid && s_aw_ready) begin
        awg_q   <= 1'b1;
        waddr_q <= s_aw_address;
      end
      if (s_w_valid && s_w_ready) begin
        smem[waddr_q] <= s_w_data;
        awg_q         <= 1'b0;
        bv_q          <= 1'b1;
      end
      if (s_b_valid && s_b_ready) bv_q <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input int m, input logic [AW-1:0] a,
                    input logic [32:0] e);
    int n;
    if (m == 0) exp_r0.push_back(e);
    else exp_r1.push_back(e);
    m_ar_address[m*AW +: AW] = a;
    m_ar_valid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!m_ar_ready[m] && n < TMO);
    chk("ar_wait", 64'(n < TMO), 64'd1);
    @(posedge clk); #1;
    m_ar_valid[m] = 1'b0;
    n = 0;
    while (!m_r_valid[m] && n < TMO) begin @(negedge clk); n++; end
    chk("r_wait", 64'(n < TMO), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wr(input int m, input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    int n;
    pend_b[m] = pend_b[m] + 1;
    m_aw_address[m*AW +: AW] = a;
    m_w_data[m*DW +: DW] = d;
    m_aw_valid[m] = 1'b1;
    m_w_valid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!m_aw_ready[m] && n < TMO);
    chk("aw_wait", 64'(n < TMO), 64'd1);
    @(posedge clk); #1;
    m_aw_valid[m] = 1'b0;
    n = 0;
    while (!m_w_ready[m] && n < TMO) begin @(negedge clk); n++; end
    chk("w_wait", 64'(n < TMO), 64'd1);
    @(posedge clk); #1;
    m_w_valid[m] = 1'b0;
    n = 0;
    while (!m_b_valid[m] && n < TMO) begin @(negedge clk); n++; end
    chk("b_wait", 64'(n < TMO), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: scoreboard pops on handshakes, grant order, isolation.
  logic        gv_q = 1'b0;
  logic [32:0] e;
  logic [1:0]  act;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = m_ar_ready[i] | m_r_valid[i] | m_aw_ready[i]
               | m_w_ready[i] | m_b_valid[i];
        if (m_r_valid[i] && m_r_ready[i]) begin
          e = '0;
          if (i == 0) begin
            chk("r_q0", 64'(exp_r0.size() > 0), 64'd1);
            if (exp_r0.size() > 0) e = exp_r0.pop_front();
          end else begin
            chk("r_q1", 64'(exp_r1.size() > 0), 64'd1);
            if (exp_r1.size() > 0) e = exp_r1.pop_front();
          end
          chk("r_data", 64'(m_r_data), 64'(e[31:0]));
          chk("r_resp", 64'(m_r_resp), 64'(e[32]));
          chk("r_other", 64'(m_r_valid[1-i]), 64'd0);
        end
        if (m_b_valid[i] && m_b_ready[i]) begin
          chk("b_q", 64'(pend_b[i] > 0), 64'd1);
          if (pend_b[i] > 0) pend_b[i] = pend_b[i] - 1;
          chk("b_resp", 64'(m_b_resp), 64'd1);
          chk("b_other", 64'(m_b_valid[1-i]), 64'd0);
        end
      end
      chk("isolate", 64'(act[0] & act[1]), 64'd0);
      if (!grant_valid)
        chk("idle_quiet", 64'({act, s_ar_valid, s_aw_valid, s_w_valid,
                               s_r_ready, s_b_ready}), 64'd0);
      if (grant_valid && !gv_q) begin
        chk("g_q", 64'(exp_g.size() > 0), 64'd1);
        if (exp_g.size() > 0)
          chk("grant_id", 64'(grant_id), 64'(exp_g.pop_front()));
      end
    end
    gv_q <= grant_valid;
  end

  initial begin
    rst = 1'b1;
    m_ar_valid = '0; m_aw_valid = '0; m_w_valid = '0;
    m_ar_address = '0; m_aw_address = '0; m_w_data = '0;
    m_r_ready = 2'b11; m_b_ready = 2'b11;
    stall_r = 1'b0;
    pend_b[0] = 0; pend_b[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gv", 64'(grant_valid), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_to", 64'(timeout_err), 64'd0);
    chk("rst_outs", 64'({m_ar_ready, m_r_valid, m_aw_ready, m_w_ready,
                         m_b_valid}), 64'd0);
    rst = 1'b0;

    // single write then read by master 0
    exp_g.push_back(1'b0);
    wr(0, 4'h3, 32'hDEADBEEF);
    ref_mem[3] = 32'hDEADBEEF;
    exp_g.push_back(1'b0);
    rd(0, 4'h3, {1'b1, ref_mem[3]});

    // simultaneous writes right after reset: m0 first
    do_reset();
    exp_g.push_back(1'b0);
    exp_g.push_back(1'b1);
    fork
      wr(0, 4'h5, 32'hA5A5A5A5);
      wr(1, 4'h6, 32'h5A5A5A5A);
    join
    ref_mem[5] = 32'hA5A5A5A5;
    ref_mem[6] = 32'h5A5A5A5A;

    // fill table through master 1
    for (int k = 7; k < 16; k++) begin
      exp_g.push_back(1'b1);
      wr(1, 4'(k), 32'h1000_0000 + 32'(k) * 32'h111);
      ref_mem[k] = 32'h1000_0000 + 32'(k) * 32'h111;
    end

    // simultaneous reads after m1 was last: m0 wins
    exp_g.push_back(1'b0);
    exp_g.push_back(1'b1);
    fork
      rd(0, 4'h5, {1'b1, ref_mem[5]});
      rd(1, 4'h6, {1'b1, ref_mem[6]});
    join

    // continuous reads from both masters alternate
    for (int k = 0; k < 4; k++) begin
      exp_g.push_back(1'b0);
      exp_g.push_back(1'b1);
    end
    fork
      begin
        for (int k = 0; k < 4; k++)
          rd(0, 4'(8 + k), {1'b1, ref_mem[8 + k]});
      end
      begin
        for (int j = 0; j < 4; j++)
          rd(1, 4'(12 + j), {1'b1, ref_mem[12 + j]});
      end
    join
    chk("fair_left", 64'(exp_g.size()), 64'd0);

    // same master read and write together: read first
    exp_g.push_back(1'b1);
    exp_g.push_back(1'b1);
    fork
      rd(1, 4'h7, {1'b1, ref_mem[7]});
      wr(1, 4'h7, 32'hCAFEF00D);
    join
    ref_mem[7] = 32'hCAFEF00D;
    exp_g.push_back(1'b1);
    rd(1, 4'h7, {1'b1, ref_mem[7]});

    // reset while in the W phase
    exp_g.push_back(1'b0);
    m_aw_address[AW-1:0] = 4'h2;
    m_aw_valid[0] = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!m_aw_ready[0] && n < TMO);
      chk("mw_aw_wait", 64'(n < TMO), 64'd1);
    end
    @(posedge clk); #1;
    m_aw_valid[0] = 1'b0;
    chk("mw_in_w", 64'({grant_valid, m_w_ready[0]}), 64'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mw_gv", 64'(grant_valid), 64'd0);
    chk("mw_outs", 64'({m_ar_ready, m_r_valid, m_aw_ready, m_w_ready,
                        m_b_valid}), 64'd0);
    rst = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // stalled read response is replaced by an error response
    stall_r = 1'b1;
    exp_g.push_back(1'b0);
    rd(0, 4'h3, {1'b0, 32'h0});
    chk("to_err_set", 64'(timeout_err), 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("to_err_hold", 64'(timeout_err), 64'd1);
    stall_r = 1'b0;
    do_reset();
    chk("to_err_clr", 64'(timeout_err), 64'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("end_to", 64'(timeout_err), 64'd0);
    chk("end_g", 64'(exp_g.size()), 64'd0);
    chk("end_r", 64'(exp_r0.size() + exp_r1.size()), 64'd0);
    chk("end_b", 64'(pend_b[0] + pend_b[1]), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
